ps2_host_tx: RTL
================

Name: ps2_host_tx

Overview:
PS/2 host-to-device transmitter: sends one command byte to the keyboard, e.g. 0xED for set-LEDs or 0xFF for reset. It is the counterpart of the keyboard scan-code receiver and shares the same PS2KeyboardClk/PS2KeyboardData pins. The pins are open-drain; the top level builds the tristates from the *_oe outputs. tx_busy gates the scan-code receiver while a command is on the wire.

Parameters:
INHIBIT_CYCLES, 5000, clock-low request time in clk cycles (100 us at 50 MHz sys_clk)
START_TIMEOUT, 750000, max cycles from end of inhibit to first device falling edge (15 ms)
FRAME_TIMEOUT, 100000, max cycles from first device falling edge to ACK sample (2 ms)

Ports:
clk  input  1  system clock (50 MHz sys_clk)
rst_n  input  1  asynchronous active-low reset
tx_data  input  8  command byte, sampled when tx_start is accepted
tx_start  input  1  one-cycle request; ignored while tx_busy=1
tx_busy  output  1  high from accept until done/error pulse
tx_done  output  1  one-cycle pulse: frame sent and device ACK received
tx_err  output  1  one-cycle pulse: missing ACK or timeout
ps2_clk_in  input  1  raw PS/2 clock pin level
ps2_data_in  input  1  raw PS/2 data pin level
ps2_clk_oe  output  1  1 = pull clock low, 0 = release
ps2_data_oe  output  1  1 = pull data low, 0 = release

Behaviour:
- Reset (async, rst_n=0): state IDLE; tx_busy, tx_done, tx_err, ps2_clk_oe and ps2_data_oe all 0. Lines are released immediately, including mid-frame. Counters and synchronizers clear, with synchronizer flops reset to 1.
- Inputs pass through 2-FF synchronizers. Falling edge (fe) = previous synced clk 1 and current 0; fe is one clk wide.
- Frame shift register of 9 bits: {parity, tx_data}. Parity = ~^tx_data (odd parity).
- States:
  - IDLE: both oe=0. On tx_start: latch the frame, tx_busy<=1, clear counter, go to INHIBIT.
  - INHIBIT: clk_oe=1, data_oe=0 for exactly INHIBIT_CYCLES cycles. Then data_oe<=1 (start bit 0), clk_oe<=0, clear counter, go to REQ.
  - REQ: wait for fe. On fe, drive data_oe = ~bit0, bit index<=1, counter cleared, go to DATA. If the counter reaches START_TIMEOUT first, go to ERR.
  - DATA: on each fe, drive data_oe = ~frame[index] and increment index. The fe that outputs index 8 (parity) moves to STOP.
  - STOP: on next fe, data_oe<=0 (stop bit 1), go to ACK.
  - ACK: on next fe, sample synced data. 0 goes to DONE; 1 goes to ERR.
  - DONE: tx_done=1 for one cycle, tx_busy<=0, return to IDLE.
  - ERR: both oe<=0, tx_err=1 for one cycle, tx_busy<=0, return to IDLE.
- From REQ entry onward, the timeout counter runs in DATA/STOP/ACK. It is cleared at first fe and then counts against FRAME_TIMEOUT; overflow in any of these states goes to ERR.
- Total device falling edges consumed per frame: 11 (8 data, parity, stop, ack).
- Data changes only on the clk cycle after fe is detected. Latency fe to data_oe update is 3 clk (2 sync + 1 register).
- tx_start while busy: dropped, no queueing. tx_start coincident with the DONE/ERR cycle: ignored.
- tx_done and tx_err are never both 1. Exactly one of them pulses per accepted tx_start, unless reset intervenes.
- Counter is 20 bits and saturates at its terminal value, with no wrap.

Test Plan:
- Send 0xED with the device model clocking at 12.5 kHz and ACK low. Required: clk_oe high exactly 5000 cycles; start bit 0; data bits on the wire 1,0,1,1,0,1,1,1; parity 1; stop 1; tx_done pulses once and tx_busy falls the same cycle.
- Send 0x01: parity bit 0. Send 0x00: parity 1. Each pulses tx_done; wire bits match LSB-first order.
- Device holds data high at the ACK clock: tx_err pulses once, tx_done stays 0, both oe=0 afterwards.
- Set START_TIMEOUT=200 and let the device never clock. tx_err pulses 200 cycles after the inhibit ends; data_oe is released.
- Device stops after 5 falling edges, with FRAME_TIMEOUT=1000. tx_err fires 1000 cycles after the first fe; lines are released.
- Assert rst_n=0 during DATA: both oe drop to 0 asynchronously, with no clock needed. After release, tx_busy=0 and a new 0xFF send completes with tx_done. A second tx_start mid-frame has no effect on the wire.

Source files
------------

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibits the bus, issues a request-to-send,
// shifts out {parity, data} on device clock falling edges and checks the device ACK.
`timescale 1ns/1ps

module ps2_host_tx #(
   parameter int unsigned INHIBIT_CYCLES = 5000,
   parameter int unsigned START_TIMEOUT  = 750000,
   parameter int unsigned FRAME_TIMEOUT  = 100000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] tx_data,
   input  logic       tx_start,
   output logic       tx_busy,
   output logic       tx_done,
   output logic       tx_err,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe
);

   localparam int CNT_W = 20;
   localparam logic [CNT_W-1:0] CNT_MAX      = '1;
   localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] START_LAST   = CNT_W'(START_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] FRAME_LAST   = CNT_W'(FRAME_TIMEOUT - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_INHIBIT,
      ST_REQ,
      ST_DATA,
      ST_STOP,
      ST_ACK,
      ST_DONE,
      ST_ERR
   } state_t;

   state_t           state_q, state_d;
   logic [8:0]       frame_q, frame_d;
   logic [3:0]       idx_q, idx_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             err_q, err_d;
   logic             clk_oe_q, clk_oe_d;
   logic             data_oe_q, data_oe_d;

   // bit 0 = PS/2 clock, bit 1 = PS/2 data; idle bus level is high
   logic [1:0]       sync1_q, sync2_q;
   logic             clk_prev_q;
   logic             ps2_clk_s;
   logic             ps2_data_s;
   logic             fe;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q    <= 2'b11;
         sync2_q    <= 2'b11;
         clk_prev_q <= 1'b1;
      end else begin
         sync1_q    <= {ps2_data_in, ps2_clk_in};
         sync2_q    <= sync1_q;
         clk_prev_q <= sync2_q[0];
      end
   end

   assign ps2_clk_s  = sync2_q[0];
   assign ps2_data_s = sync2_q[1];
   assign fe         = clk_prev_q & ~ps2_clk_s;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         frame_q   <= '0;
         idx_q     <= '0;
         cnt_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         clk_oe_q  <= 1'b0;
         data_oe_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         frame_q   <= frame_d;
         idx_q     <= idx_d;
         cnt_q     <= cnt_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         err_q     <= err_d;
         clk_oe_q  <= clk_oe_d;
         data_oe_q <= data_oe_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      frame_d   = frame_q;
      idx_d     = idx_q;
      cnt_d     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
      busy_d    = busy_q;
      done_d    = 1'b0;
      err_d     = 1'b0;
      clk_oe_d  = clk_oe_q;
      data_oe_d = data_oe_q;

      case (state_q)
         ST_IDLE: begin
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            cnt_d     = '0;
            if (tx_start) begin
               frame_d  = {~^tx_data, tx_data};
               busy_d   = 1'b1;
               clk_oe_d = 1'b1;
               state_d  = ST_INHIBIT;
            end
         end

         ST_INHIBIT: begin
            if (cnt_q >= INHIBIT_LAST) begin
               clk_oe_d  = 1'b0;
               data_oe_d = 1'b1;
               cnt_d     = '0;
               state_d   = ST_REQ;
            end
         end

         ST_REQ: begin
            if (fe) begin
               data_oe_d = ~frame_q[0];
               idx_d     = 4'd1;
               cnt_d     = '0;
               state_d   = ST_DATA;
            end else if (cnt_q >= START_LAST) begin
               state_d = ST_ERR;
            end
         end

         // the frame counter keeps running across DATA/STOP/ACK from the first edge
         ST_DATA: begin
            if (cnt_q >= FRAME_LAST) begin
               state_d = ST_ERR;
            end else if (fe) begin
               data_oe_d = ~frame_q[idx_q];
               if (idx_q == 4'd8) begin
                  state_d = ST_STOP;
               end else begin
                  idx_d = idx_q + 4'd1;
               end
            end
         end

         ST_STOP: begin
            if (cnt_q >= FRAME_LAST) begin
               state_d = ST_ERR;
            end else if (fe) begin
               data_oe_d = 1'b0;
               state_d   = ST_ACK;
            end
         end

         ST_ACK: begin
            if (cnt_q >= FRAME_LAST) begin
               state_d = ST_ERR;
            end else if (fe) begin
               if (!ps2_data_s) begin
                  done_d    = 1'b1;
                  busy_d    = 1'b0;
                  clk_oe_d  = 1'b0;
                  data_oe_d = 1'b0;
                  state_d   = ST_DONE;
               end else begin
                  state_d = ST_ERR;
               end
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         ST_ERR: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // every path into ERR releases the bus and pulses the error flag exactly once
      if (state_d == ST_ERR && state_q != ST_ERR) begin
         err_d     = 1'b1;
         busy_d    = 1'b0;
         clk_oe_d  = 1'b0;
         data_oe_d = 1'b0;
      end
   end

   assign tx_busy     = busy_q;
   assign tx_done     = done_q;
   assign tx_err      = err_q;
   assign ps2_clk_oe  = clk_oe_q;
   assign ps2_data_oe = data_oe_q;

endmodule
